// File: rtl/sh_divu_gen.sv
// Sequential restoring divider: W-bit quotient/remainder from a 2W- or W-bit dividend,
// signed or unsigned at run time, with early overflow / divide-by-zero exit and abort.
module sh_divu_gen #(
    parameter int W   = 32,
    parameter bit SAT = 1'b1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         CE,
    input  logic         START,
    input  logic         ABORT,
    input  logic         SIGNED,
    input  logic         LONG,
    input  logic [W-1:0] DVD_H,
    input  logic [W-1:0] DVD_L,
    input  logic [W-1:0] DVSR,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] QUO,
    output logic [W-1:0] REM,
    output logic         OVF,
    output logic         DIV0,
    output logic [2:0]   DBG_STATE
);

    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic          sgn_q, long_q;
    logic [W-1:0]  dvd_h_q, dvd_l_q, dvsr_q;
    logic [W:0]    r_q, d_q;
    logic [W-1:0]  q_q;
    logic [CW-1:0] cnt_q;
    logic          sd_q, s_q, ovf_q, div0_q;
    logic [W-1:0]  quo_q, rem_q;
    logic          ovf_o_q, div0_o_q;

    // Operand conditioning, evaluated from the latched operands during PREP.
    logic [W-1:0]   hi_w;
    logic [2*W:0]   dvd_x, dvd_mag;
    logic [W:0]     dvsr_x, dvsr_mag;
    logic           sd_c, sv_c, early_ovf, dvsr_zero;

    assign hi_w      = long_q ? dvd_h_q : {W{sgn_q & dvd_l_q[W-1]}};
    assign sd_c      = sgn_q & hi_w[W-1];
    assign sv_c      = sgn_q & dvsr_q[W-1];
    assign dvd_x     = {sd_c, hi_w, dvd_l_q};
    assign dvd_mag   = sd_c ? -dvd_x : dvd_x;
    assign dvsr_x    = {sv_c, dvsr_q};
    assign dvsr_mag  = sv_c ? -dvsr_x : dvsr_x;
    assign dvsr_zero = (dvsr_q == '0);
    // Quotient needs more than W bits whenever the upper half already reaches the divisor.
    assign early_ovf = dvsr_zero || (dvd_mag[2*W:W] >= dvsr_mag);

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    logic [W+1:0] r2, diff;
    logic         ge;

    assign r2   = {r_q, q_q[W-1]};
    assign diff = r2 - {1'b0, d_q};
    assign ge   = ~diff[W+1];

    // Sign fix-up and signed range check.
    logic [W-1:0] rmag, quo_calc, rem_calc, sat_quo, ovf_quo;
    logic         range_ovf, ovf_fix;

    assign rmag      = r_q[W-1:0];
    assign quo_calc  = s_q ? -q_q : q_q;
    assign rem_calc  = sd_q ? -rmag : rmag;
    assign range_ovf = sgn_q & (s_q ? (q_q[W-1] & (|q_q[W-2:0])) : q_q[W-1]);
    assign ovf_fix   = ovf_q | range_ovf;
    assign sat_quo   = sgn_q ? {s_q, {(W-1){~s_q}}} : {W{1'b1}};
    assign ovf_quo   = SAT ? sat_quo : dvd_l_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else if (CE) begin
            state_q <= state_d;
        end
    end

    // The early-exit path also passes through FIX so results are always committed from one place.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (START) state_d = S_PREP;
            S_PREP: state_d = early_ovf ? S_FIX : S_ITER;
            S_ITER: if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && ABORT) state_d = S_IDLE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sgn_q    <= 1'b0;
            long_q   <= 1'b0;
            dvd_h_q  <= '0;
            dvd_l_q  <= '0;
            dvsr_q   <= '0;
            r_q      <= '0;
            d_q      <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
            sd_q     <= 1'b0;
            s_q      <= 1'b0;
            ovf_q    <= 1'b0;
            div0_q   <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            ovf_o_q  <= 1'b0;
            div0_o_q <= 1'b0;
        end else if (CE) begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        sgn_q    <= SIGNED;
                        long_q   <= LONG;
                        dvd_h_q  <= DVD_H;
                        dvd_l_q  <= DVD_L;
                        dvsr_q   <= DVSR;
                        ovf_q    <= 1'b0;
                        div0_q   <= 1'b0;
                        ovf_o_q  <= 1'b0;
                        div0_o_q <= 1'b0;
                    end
                end
                S_PREP: begin
                    r_q    <= dvd_mag[2*W:W];
                    q_q    <= dvd_mag[W-1:0];
                    d_q    <= dvsr_mag;
                    sd_q   <= sd_c;
                    s_q    <= sd_c ^ sv_c;
                    ovf_q  <= early_ovf;
                    div0_q <= dvsr_zero;
                    cnt_q  <= CW'(W - 1);
                end
                S_ITER: begin
                    r_q   <= ge ? diff[W:0] : r2[W:0];
                    q_q   <= {q_q[W-2:0], ge};
                    cnt_q <= cnt_q - 1'b1;
                end
                S_FIX: begin
                    if (!ABORT) begin
                        quo_q    <= ovf_fix ? ovf_quo : quo_calc;
                        rem_q    <= ovf_fix ? hi_w : rem_calc;
                        ovf_o_q  <= ovf_fix;
                        div0_o_q <= div0_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = (state_q == S_DONE);
    assign QUO       = quo_q;
    assign REM       = rem_q;
    assign OVF       = ovf_o_q;
    assign DIV0      = div0_o_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_sh_divu_gen.sv
// Directed bench for sh_divu_gen at W=32 (SAT=1 and SAT=0), W=16 and W=8.
module tb_sh_divu_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, ce, abort, sgn, lng;
    logic        start32, start16, start8;
    logic [31:0] h32, l32, d32;

    logic        busy32, done32, ovf32, dz32;
    logic [31:0] quo32, rem32;
    logic [2:0]  st32;
    logic        busy0, done0, ovf0, dz0;
    logic [31:0] quo0, rem0;
    logic [2:0]  st0;
    logic        busy16, done16, ovf16, dz16;
    logic [15:0] quo16, rem16;
    logic [2:0]  st16;
    logic        busy8, done8, ovf8, dz8;
    logic [7:0]  quo8, rem8;
    logic [2:0]  st8;

    sh_divu_gen #(.W(32), .SAT(1'b1)) dut32 (
        .CLK(clk), .RST_N(rst_n), .CE(ce), .START(start32), .ABORT(abort),
        .SIGNED(sgn), .LONG(lng), .DVD_H(h32), .DVD_L(l32), .DVSR(d32),
        .BUSY(busy32), .DONE(done32), .QUO(quo32), .REM(rem32), .OVF(ovf32),
        .DIV0(dz32), .DBG_STATE(st32));

    sh_divu_gen #(.W(32), .SAT(1'b0)) dut32s0 (
        .CLK(clk), .RST_N(rst_n), .CE(ce), .START(start32), .ABORT(abort),
        .SIGNED(sgn), .LONG(lng), .DVD_H(h32), .DVD_L(l32), .DVSR(d32),
        .BUSY(busy0), .DONE(done0), .QUO(quo0), .REM(rem0), .OVF(ovf0),
        .DIV0(dz0), .DBG_STATE(st0));

    sh_divu_gen #(.W(16), .SAT(1'b1)) dut16 (
        .CLK(clk), .RST_N(rst_n), .CE(ce), .START(start16), .ABORT(abort),
        .SIGNED(sgn), .LONG(lng), .DVD_H(h32[15:0]), .DVD_L(l32[15:0]), .DVSR(d32[15:0]),
        .BUSY(busy16), .DONE(done16), .QUO(quo16), .REM(rem16), .OVF(ovf16),
        .DIV0(dz16), .DBG_STATE(st16));

    sh_divu_gen #(.W(8), .SAT(1'b1)) dut8 (
        .CLK(clk), .RST_N(rst_n), .CE(ce), .START(start8), .ABORT(abort),
        .SIGNED(sgn), .LONG(lng), .DVD_H(h32[7:0]), .DVD_L(l32[7:0]), .DVSR(d32[7:0]),
        .BUSY(busy8), .DONE(done8), .QUO(quo8), .REM(rem8), .OVF(ovf8),
        .DIV0(dz8), .DBG_STATE(st8));

    int checks = 0;
    int errors = 0;

    logic [31:0] res_q, res_r, res_q0;
    logic        res_ovf, res_dz;
    int          res_lat;

    typedef struct {
        int          w;
        logic        sg;
        logic        lg;
        logic [31:0] h, l, d, q, r;
        logic        ovf, dz;
        int          lat;
    } vec_t;

    function automatic logic sel_done(input int w);
        case (w)
            32:      return done32;
            16:      return done16;
            default: return done8;
        endcase
    endfunction

    // Start one division on the selected instance and wait for DONE, counting CE edges.
    task automatic run_op(input int w, input logic sg, input logic lg,
                          input logic [31:0] h, input logic [31:0] l, input logic [31:0] d,
                          input bit tog);
        int guard;
        @(negedge clk);
        sgn = sg; lng = lg; h32 = h; l32 = l; d32 = d; ce = 1'b1;
        start32 = (w == 32); start16 = (w == 16); start8 = (w == 8);
        @(negedge clk);
        start32 = 1'b0; start16 = 1'b0; start8 = 1'b0;
        res_lat = 0;
        guard = 0;
        while (!sel_done(w) && guard < 2000) begin
            if (tog) ce = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (ce) res_lat++;
            guard++;
        end
        ce = 1'b1;
        checks++;
        if (!sel_done(w)) begin
            errors++;
            $display("FAIL timeout_w%0d: DONE not seen after %0d cycles, expected within %0d", w, guard, w + 2);
        end
        case (w)
            32: begin res_q = quo32; res_r = rem32; res_ovf = ovf32; res_dz = dz32; end
            16: begin res_q = {16'h0, quo16}; res_r = {16'h0, rem16}; res_ovf = ovf16; res_dz = dz16; end
            default: begin res_q = {24'h0, quo8}; res_r = {24'h0, rem8}; res_ovf = ovf8; res_dz = dz8; end
        endcase
        res_q0 = quo0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce = 1'b1; abort = 1'b0; sgn = 1'b0; lng = 1'b0;
        start32 = 1'b0; start16 = 1'b0; start8 = 1'b0;
        h32 = '0; l32 = '0; d32 = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy32); end
        checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done32); end
        checks++; if (quo32 !== 32'h0) begin errors++; $display("FAIL reset_quo: got %h expected 0", quo32); end
        checks++; if (rem32 !== 32'h0) begin errors++; $display("FAIL reset_rem: got %h expected 0", rem32); end
        checks++; if ({ovf32, dz32} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {ovf32, dz32}); end
        checks++; if (st32 !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", st32); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        vec_t v[$];
        v.push_back('{32, 1'b0, 1'b0, 32'h0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 34});
        v.push_back('{32, 1'b1, 1'b0, 32'h0, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 34});
        v.push_back('{32, 1'b1, 1'b0, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 34});
        v.push_back('{32, 1'b0, 1'b1, 32'd5, 32'h0, 32'd3, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0, 2});
        v.push_back('{32, 1'b1, 1'b0, 32'h0, 32'h10, 32'h0, 32'h7FFFFFFF, 32'h0, 1'b1, 1'b1, 2});
        v.push_back('{32, 1'b0, 1'b1, 32'd1, 32'h0, 32'd2, 32'h80000000, 32'h0, 1'b0, 1'b0, 34});
        v.push_back('{16, 1'b1, 1'b1, 32'hFFFF, 32'h8000, 32'h2, 32'hC000, 32'h0, 1'b0, 1'b0, 18});
        v.push_back('{16, 1'b0, 1'b0, 32'h0, 32'hFFFF, 32'h10, 32'h0FFF, 32'hF, 1'b0, 1'b0, 18});
        v.push_back('{16, 1'b1, 1'b0, 32'h0, 32'h8000, 32'hFFFF, 32'h7FFF, 32'hFFFF, 1'b1, 1'b0, 18});
        v.push_back('{16, 1'b0, 1'b1, 32'h1, 32'h0, 32'h3, 32'h5555, 32'h1, 1'b0, 1'b0, 18});
        v.push_back('{8, 1'b0, 1'b0, 32'h0, 32'hC8, 32'h9, 32'h16, 32'h2, 1'b0, 1'b0, 10});
        v.push_back('{8, 1'b1, 1'b0, 32'h0, 32'hF9, 32'h2, 32'hFD, 32'hFF, 1'b0, 1'b0, 10});
        v.push_back('{8, 1'b1, 1'b0, 32'h0, 32'h07, 32'hFE, 32'hFD, 32'h01, 1'b0, 1'b0, 10});
        v.push_back('{8, 1'b1, 1'b1, 32'h02, 32'h00, 32'h10, 32'h20, 32'h0, 1'b0, 1'b0, 10});
        v.push_back('{8, 1'b1, 1'b0, 32'h0, 32'h80, 32'hFF, 32'h7F, 32'hFF, 1'b1, 1'b0, 10});
        v.push_back('{8, 1'b0, 1'b1, 32'h10, 32'h00, 32'h08, 32'hFF, 32'h10, 1'b1, 1'b0, 2});
        v.push_back('{8, 1'b1, 1'b0, 32'h0, 32'h80, 32'h01, 32'h80, 32'h0, 1'b0, 1'b0, 10});
        v.push_back('{8, 1'b1, 1'b0, 32'h0, 32'h80, 32'h02, 32'hC0, 32'h0, 1'b0, 1'b0, 10});
        foreach (v[i]) begin
            run_op(v[i].w, v[i].sg, v[i].lg, v[i].h, v[i].l, v[i].d, 1'b0);
            checks++; if (res_q !== v[i].q) begin errors++; $display("FAIL vec%0d_quo: got %h expected %h", i, res_q, v[i].q); end
            checks++; if (res_r !== v[i].r) begin errors++; $display("FAIL vec%0d_rem: got %h expected %h", i, res_r, v[i].r); end
            checks++; if (res_ovf !== v[i].ovf) begin errors++; $display("FAIL vec%0d_ovf: got %b expected %b", i, res_ovf, v[i].ovf); end
            checks++; if (res_dz !== v[i].dz) begin errors++; $display("FAIL vec%0d_div0: got %b expected %b", i, res_dz, v[i].dz); end
            checks++; if (res_lat != v[i].lat) begin errors++; $display("FAIL vec%0d_latency: got %0d expected %0d", i, res_lat, v[i].lat); end
        end
    endtask

    task automatic test_sat0();
        run_op(32, 1'b0, 1'b1, 32'd5, 32'h0, 32'd3, 1'b0);
        checks++; if (res_q0 !== 32'h0) begin errors++; $display("FAIL sat0_early_quo: got %h expected 00000000", res_q0); end
        checks++; if (rem0 !== 32'd5) begin errors++; $display("FAIL sat0_early_rem: got %h expected 00000005", rem0); end
        run_op(32, 1'b1, 1'b0, 32'h0, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        checks++; if (res_q0 !== 32'h80000000) begin errors++; $display("FAIL sat0_range_quo: got %h expected 80000000", res_q0); end
        checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL sat0_range_ovf: got %b expected 1", ovf0); end
        run_op(32, 1'b0, 1'b0, 32'h0, 32'd100, 32'd7, 1'b0);
        checks++; if (res_q0 !== 32'd14) begin errors++; $display("FAIL sat0_normal_quo: got %h expected 0000000e", res_q0); end
    endtask

    task automatic test_done_pulse();
        run_op(32, 1'b0, 1'b0, 32'h0, 32'd1000, 32'd10, 1'b0);
        @(negedge clk);
        checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b expected 0", done32); end
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %b expected 0", busy32); end
        checks++; if (quo32 !== 32'd100) begin errors++; $display("FAIL quo_hold: got %h expected 00000064", quo32); end
    endtask

    task automatic test_back_to_back();
        run_op(32, 1'b0, 1'b0, 32'h0, 32'd77, 32'd5, 1'b0);
        checks++; if (res_q !== 32'd15) begin errors++; $display("FAIL b2b_first_quo: got %h expected 0000000f", res_q); end
        run_op(32, 1'b1, 1'b0, 32'h0, 32'hFFFFFFB3, 32'd5, 1'b0);
        checks++; if (res_q !== 32'hFFFFFFF1) begin errors++; $display("FAIL b2b_second_quo: got %h expected fffffff1", res_q); end
        checks++; if (res_r !== 32'hFFFFFFFE) begin errors++; $display("FAIL b2b_second_rem: got %h expected fffffffe", res_r); end
    endtask

    task automatic test_start_ignored();
        int guard, lat;
        @(negedge clk);
        sgn = 1'b0; lng = 1'b0; h32 = '0; l32 = 32'd100; d32 = 32'd7; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0; lat = 0;
        repeat (5) begin @(negedge clk); lat++; end
        l32 = 32'd50; d32 = 32'd5; start32 = 1'b1;
        @(negedge clk); lat++;
        start32 = 1'b0;
        guard = 0;
        while (!done32 && guard < 200) begin @(negedge clk); lat++; guard++; end
        checks++; if (lat != 34) begin errors++; $display("FAIL start_ignored_latency: got %0d expected 34", lat); end
        checks++; if (quo32 !== 32'd14) begin errors++; $display("FAIL start_ignored_quo: got %h expected 0000000e", quo32); end
        checks++; if (rem32 !== 32'd2) begin errors++; $display("FAIL start_ignored_rem: got %h expected 00000002", rem32); end
    endtask

    task automatic test_abort();
        int seen;
        run_op(32, 1'b1, 1'b0, 32'h0, 32'h10, 32'h0, 1'b0);
        @(negedge clk);
        sgn = 1'b0; lng = 1'b0; l32 = 32'd100; d32 = 32'd7; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (11) @(negedge clk);
        checks++; if (busy32 !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", busy32); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b expected 0", busy32); end
        checks++; if ({ovf32, dz32} !== 2'b00) begin errors++; $display("FAIL abort_flags: got %b expected 00", {ovf32, dz32}); end
        checks++; if (quo32 !== 32'h7FFFFFFF) begin errors++; $display("FAIL abort_quo_kept: got %h expected 7fffffff", quo32); end
        seen = 0;
        repeat (40) begin @(negedge clk); if (done32 || busy32) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen); end
    endtask

    task automatic test_ce_toggle();
        run_op(32, 1'b0, 1'b0, 32'h0, 32'd100, 32'd7, 1'b1);
        checks++; if (res_q !== 32'd14) begin errors++; $display("FAIL ce_quo: got %h expected 0000000e", res_q); end
        checks++; if (res_lat != 34) begin errors++; $display("FAIL ce_latency: got %0d expected 34", res_lat); end
        run_op(32, 1'b1, 1'b0, 32'h0, 32'hFFFFFF9C, 32'd7, 1'b1);
        checks++; if (res_r !== 32'hFFFFFFFE) begin errors++; $display("FAIL ce_signed_rem: got %h expected fffffffe", res_r); end
        checks++; if (res_lat != 34) begin errors++; $display("FAIL ce_signed_latency: got %0d expected 34", res_lat); end
        run_op(8, 1'b0, 1'b1, 32'h10, 32'h0, 32'h8, 1'b1);
        checks++; if (res_lat != 2) begin errors++; $display("FAIL ce_early_latency: got %0d expected 2", res_lat); end
        // A frozen DONE stays high across CE=0 cycles.
        run_op(8, 1'b0, 1'b0, 32'h0, 32'hC8, 32'h9, 1'b0);
        ce = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (done8 !== 1'b1) begin errors++; $display("FAIL ce_done_stretch: got %b expected 1", done8); end
        ce = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        run_op(32, 1'b0, 1'b0, 32'h0, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        l32 = 32'd900; d32 = 32'd7; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy32); end
        checks++; if (quo32 !== 32'h0) begin errors++; $display("FAIL areset_quo: got %h expected 0", quo32); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (done32 !== 1'b0 || quo32 !== 32'h0) begin errors++; $display("FAIL areset_no_done: done %b quo %h expected 0 0", done32, quo32); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_sat0();
        test_done_pulse();
        test_back_to_back();
        test_start_ignored();
        test_abort();
        test_ce_toggle();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
